// File: rtl/mem_pkg.sv
// Shared types and constants for the line-granular backing store.
package mem_pkg;

   localparam int LINE_W  = 128;
   localparam int ADDR_W  = 10;
   localparam int WORD_W  = 64;
   localparam int IDX_LSB = 3;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

   // word0 sits in the upper half of the line
   typedef struct packed {
      logic [WORD_W-1:0] word0;
      logic [WORD_W-1:0] word1;
   } line_t;

   function automatic int unsigned lineIndex(input logic [ADDR_W-1:0] addr,
                                             input int unsigned lines);
      return 32'(addr[ADDR_W-1:IDX_LSB]) % lines;
   endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// 4-bit down-counter that paces an access; zero marks the last BUSY cycle.
module mem_latency_timer (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] loadValue,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= loadValue;
      else if (dec && count != 4'd0)
         count <= count - 4'd1;
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/line_memory.sv
// 128-bit line store with programmable access latency and a single outstanding access.
// Optional completed-access counters are built when MEM_STATS_EN is defined.
module line_memory
   import mem_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int LINES     = 128,
   parameter     INIT_FILE = ""
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_write,
   output logic [LINE_W-1:0] resp_rdata,
   output logic              busy
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       stat_reads,
   output logic [15:0]       stat_writes
`endif
);

   localparam int         IDX_W    = $clog2(LINES);
   localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

   mem_state_t       state;
   logic             capWrite;
   logic [IDX_W-1:0] capIdx;
   line_t            capData;
   logic             timerZero;
   logic             accept;
   logic             finish;

   logic [LINE_W-1:0] mem [LINES];

   initial for (int i = 0; i < LINES; i++) mem[i] = '0;

   // req_ready is also high in RESP so a new access can start on the edge leaving RESP
   assign accept = req_valid && req_ready;
   assign finish = (state == BUSY) && timerZero;

   mem_latency_timer uTimer (
      .clock    (clock),
      .reset    (reset),
      .load     (accept),
      .loadValue(LOAD_VAL),
      .dec      (state == BUSY),
      .zero     (timerZero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_write <= 1'b0;
         resp_rdata <= '0;
         busy       <= 1'b0;
         capWrite   <= 1'b0;
         capIdx     <= '0;
         capData    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  state     <= BUSY;
                  capWrite  <= req_write;
                  capIdx    <= IDX_W'(lineIndex(req_addr, int'(LINES)));
                  capData   <= line_t'(req_wdata);
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            BUSY: begin
               if (timerZero) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_write <= capWrite;
                  if (!capWrite)
                     resp_rdata <= mem[capIdx];
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // An access aborted by reset never reaches the array
   always_ff @(posedge clock) begin
      if (!reset && finish && capWrite)
         mem[capIdx] <= capData;
   end

`ifdef MEM_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_reads  <= '0;
         stat_writes <= '0;
      end else if (state == RESP) begin
         if (resp_write) begin
            if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
         end else begin
            if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: timestamp-based reference model, directed cases and random traffic.
module tb_line_memory;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         aReqValid, aReqReady, aReqWrite, aRespValid, aRespWrite, aBusy;
   logic [9:0]   aReqAddr;
   logic [127:0] aReqWdata, aRespRdata;
   logic         bReqValid, bReqReady, bReqWrite, bRespValid, bRespWrite, bBusy;
   logic [9:0]   bReqAddr;
   logic [127:0] bReqWdata, bRespRdata;
`ifdef MEM_STATS_EN
   logic [15:0]  aStatReads, aStatWrites, bStatReads, bStatWrites;
`endif

   line_memory #(.LATENCY(LAT)) dutA (
      .clock(clk), .reset(rst),
      .req_valid(aReqValid), .req_ready(aReqReady), .req_write(aReqWrite),
      .req_addr(aReqAddr), .req_wdata(aReqWdata),
      .resp_valid(aRespValid), .resp_write(aRespWrite), .resp_rdata(aRespRdata),
      .busy(aBusy)
`ifdef MEM_STATS_EN
      , .stat_reads(aStatReads), .stat_writes(aStatWrites)
`endif
   );

   line_memory #(.LATENCY(1), .LINES(16)) dutB (
      .clock(clk), .reset(rst),
      .req_valid(bReqValid), .req_ready(bReqReady), .req_write(bReqWrite),
      .req_addr(bReqAddr), .req_wdata(bReqWdata),
      .resp_valid(bRespValid), .resp_write(bRespWrite), .resp_rdata(bRespRdata),
      .busy(bBusy)
`ifdef MEM_STATS_EN
      , .stat_reads(bStatReads), .stat_writes(bStatWrites)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: an access accepted at edge e completes at edge e+LAT,
   // and the next one may be accepted from edge e+LAT+1.
   logic [127:0] mMem [128];
   int           cyc = 0;
   int           freeAt = 0;
   bit           pend = 0;
   int           accEdge = 0, respEdge = 0;
   bit           pWrite;
   int           pIdx;
   logic [127:0] pData;
   logic [127:0] mRdata = '0;
   int           mReads = 0, mWrites = 0;
   bit           lastAccepted = 0;
   int           respCount = 0, acceptCount = 0;
   int           obsRespCyc = -1;
   logic [127:0] obsRdata;
   logic         obsRespWrite;

   task automatic tick();
      bit respExp;
      @(posedge clk);
      cyc++;
      lastAccepted = 0;
      if (rst) begin
         pend = 0; freeAt = cyc + 1; mRdata = '0; mReads = 0; mWrites = 0;
      end else begin
         if (pend && cyc == respEdge) begin
            if (pWrite) begin mMem[pIdx] = pData; mWrites++; end
            else begin mRdata = mMem[pIdx]; mReads++; end
         end
         if (aReqValid && cyc >= freeAt) begin
            pend = 1; accEdge = cyc; respEdge = cyc + LAT; freeAt = cyc + LAT + 1;
            pWrite = aReqWrite; pIdx = int'(aReqAddr[9:3]); pData = aReqWdata;
            lastAccepted = 1; acceptCount++;
         end
      end
      #1;
      respExp = pend && cyc == respEdge;
      check("resp_valid", aRespValid, respExp);
      if (respExp) check("resp_write", aRespWrite, pWrite);
      check("resp_rdata", aRespRdata, mRdata);
      check("req_ready", aReqReady, cyc + 1 >= freeAt);
      check("busy", aBusy, pend && cyc >= accEdge && cyc <= respEdge);
`ifdef MEM_STATS_EN
      if (!respExp) begin
         check("stat_reads", aStatReads, mReads);
         check("stat_writes", aStatWrites, mWrites);
      end
`endif
      if (aRespValid) begin
         respCount++; obsRespCyc = cyc; obsRdata = aRespRdata; obsRespWrite = aRespWrite;
      end
   endtask

   int readyLow;

   task automatic doReq(input bit w, input logic [9:0] a, input logic [127:0] d,
                        input bit hold, input logic [9:0] holdAddr);
      int n;
      aReqValid = 1; aReqWrite = w; aReqAddr = a; aReqWdata = d;
      n = 0;
      do begin tick(); n++; end while (!lastAccepted && n < 50);
      if (!lastAccepted) check("accept_timeout", 0, 1);
      if (hold) aReqAddr = holdAddr; else aReqValid = 0;
      readyLow = aReqReady ? 0 : 1;
      obsRespCyc = -1;
      n = 0;
      while (obsRespCyc < 0 && n < 50) begin
         tick(); n++;
         if (!aReqReady) readyLow++;
      end
      if (obsRespCyc < 0) check("resp_timeout", 0, 1);
      aReqValid = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   localparam logic [127:0] DB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] PV = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

   int c0, r0, b1, b2;

   initial begin
      for (int i = 0; i < 128; i++) mMem[i] = '0;
      aReqValid = 0; aReqWrite = 0; aReqAddr = '0; aReqWdata = '0;
      bReqValid = 0; bReqWrite = 0; bReqAddr = '0; bReqWdata = '0;
      idle(2);
      rst = 0;

      // read of an untouched line
      doReq(0, 10'h000, '0, 0, '0);
      check("t1_latency", obsRespCyc - accEdge, 4);
      check("t1_rdata", obsRdata, '0);
      check("t1_ready_low", readyLow, 4);
      idle(1);

      // write then read same line at a different byte offset
      doReq(1, 10'h1A8, DB, 0, '0);
      check("t2_wr_echo", obsRespWrite, 1);
      doReq(0, 10'h1AC, '0, 0, '0);
      check("t2_rdata", obsRdata, DB);
      check("t2_rd_echo", obsRespWrite, 0);
      idle(2);

      // request held with a different address while busy
      c0 = acceptCount; r0 = respCount;
      doReq(0, 10'h1A8, '0, 1, 10'h3F8);
      idle(3);
      check("t3_accepts", acceptCount - c0, 1);
      check("t3_resps", respCount - r0, 1);
      check("t3_rdata", obsRdata, DB);

      // reset two cycles into a write aborts it
      doReq(1, 10'h3F8, PV, 0, '0);
      idle(1);
      aReqValid = 1; aReqWrite = 1; aReqAddr = 10'h3F8; aReqWdata = ~PV;
      tick();
      check("t4_accepted", lastAccepted, 1);
      aReqValid = 0;
      r0 = respCount;
      idle(2);
      rst = 1; tick(); rst = 0;
      idle(6);
      check("t4_no_resp", respCount - r0, 0);
      doReq(0, 10'h3F8, '0, 0, '0);
      check("t4_rdata", obsRdata, PV);

      // access counters from a fresh reset
      rst = 1; tick(); rst = 0;
      doReq(0, 10'h000, '0, 0, '0);
      doReq(1, 10'h010, PV, 0, '0);
      doReq(0, 10'h010, '0, 0, '0);
      doReq(1, 10'h018, DB, 0, '0);
      doReq(0, 10'h018, '0, 0, '0);
      idle(2);
`ifdef MEM_STATS_EN
      check("t6_reads", aStatReads, 3);
      check("t6_writes", aStatWrites, 2);
      rst = 1; tick(); rst = 0;
      check("t6_reads_clr", aStatReads, 0);
      check("t6_writes_clr", aStatWrites, 0);
`endif

      // random traffic over a small pool of lines
      for (int i = 0; i < 2000; i++) begin
         aReqValid = ($urandom_range(0, 1) == 1);
         aReqWrite = ($urandom_range(0, 1) == 1);
         aReqAddr  = {$urandom_range(0, 7) == 0 ? 7'($urandom) : 7'($urandom_range(60, 67)),
                      3'($urandom)};
         aReqWdata = {$urandom, $urandom, $urandom, $urandom};
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 0; aReqValid = 0;
      idle(LAT + 2);

      // LATENCY=1 instance: back-to-back reads
      check("t5_ready0", bReqReady, 1);
      bReqValid = 1; bReqWrite = 0; bReqAddr = 10'h008;
      tick();
      check("t5_ready1", bReqReady, 0);
      check("t5_nresp1", bRespValid, 0);
      bReqAddr = 10'h010;
      tick();
      check("t5_resp1", bRespValid, 1);
      check("t5_ready2", bReqReady, 1);
      b1 = cyc;
      tick();
      bReqValid = 0;
      check("t5_nresp2", bRespValid, 0);
      tick();
      check("t5_resp2", bRespValid, 1);
      b2 = cyc;
      check("t5_spacing", b2 - b1, 2);
      idle(2);

      // index wraps modulo LINES: 0x090 and 0x010 share line 2
      bReqValid = 1; bReqWrite = 1; bReqAddr = 10'h090; bReqWdata = PV;
      tick();
      bReqValid = 0;
      idle(2);
      bReqValid = 1; bReqWrite = 0; bReqAddr = 10'h010;
      tick();
      bReqValid = 0;
      tick();
      check("t5_wrap_valid", bRespValid, 1);
      check("t5_wrap_rdata", bRespRdata, PV);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
